banner_overlay_display: RTL and testbench
=========================================

Name: banner_overlay_display

Overview:
- Parametrised full-screen overlay sprite generator for banners such as GAME OVER, STAGE CLEAR and PAUSE.
- On request, the banner slides down from a start row to its final row, one step per frame. It then holds or blinks.
- Looks up pixels in an external synchronous ROM with integer upscaling and a transparency key.
- Sits between the VGA pixel-coordinate generator and the top-level colour priority mux.

Parameters:
- WIDTH, 472: banner width in screen pixels.
- HEIGHT, 320: banner height in screen pixels.
- SCALE_SHIFT, 1: ROM-to-screen upscale, expressed as log2 (0 = 1x, 1 = 2x, 2 = 4x).
- X_POS, 84: left screen column (fixed).
- Y_START, 0: top row at the start of the slide. Must satisfy Y_START <= Y_FINAL.
- Y_FINAL, 80: top row when the slide is complete.
- SLIDE_STEP, 4: rows moved per frame tick.
- BLINK_FRAMES, 30: frames per blink half-period. 0 means static hold with no blinking.
- TRANSPARENT, 12'h3b9: colour key treated as see-through.
- ROM_XW, 8: ROM x address width.
- ROM_YW, 8: ROM y address width.

Ports:
- clk, in, 1: pixel clock.
- rst, in, 1: asynchronous, active-high reset.
- show, in, 1: level request. High means display the banner.
- frame_tick, in, 1: one-cycle pulse per frame, issued at the start of vertical blank.
- xg, in, 10: current pixel column.
- yg, in, 10: current pixel row.
- rom_x, out, ROM_XW: ROM column address (combinational).
- rom_y, out, ROM_YW: ROM row address (combinational).
- rom_rgb, in, 12: ROM data, valid one cycle after the address is presented.
- rgb, out, 12: pixel colour, aligned with `on`.
- on, out, 1: banner pixel is opaque and visible this cycle.
- settled, out, 1: slide is complete (state HOLD).

Behaviour:
- Reset values: state = HIDDEN, top = Y_START, visible = 0, blink_cnt = 0, in_box_q = 0, on = 0, settled = 0. The `rgb` output passes `rom_rgb` through, so its value is don't-care while on = 0.
- FSM states: HIDDEN, SLIDE, HOLD.
- Every state: show = 0 forces HIDDEN on the next clock. top and blink_cnt are reset and visible is cleared, mid-slide or mid-blink alike.
- HIDDEN: when show = 1, go to SLIDE with top = Y_START and visible = 1.
- SLIDE: position updates happen only on frame_tick, so there is no tearing mid-frame.
  - On each frame_tick, top <= min(top + SLIDE_STEP, Y_FINAL), computed in 11 bits.
  - The tick that reaches Y_FINAL also moves the FSM to HOLD.
  - If Y_START == Y_FINAL, the first frame_tick goes straight to HOLD.
- HOLD: settled = 1.
  - If BLINK_FRAMES = 0, visible stays 1.
  - Otherwise each frame_tick increments blink_cnt. When blink_cnt == BLINK_FRAMES - 1 on a tick, blink_cnt wraps to 0 and visible toggles.
  - The first toggle therefore happens on the BLINK_FRAMES-th tick after entering HOLD.
- Simultaneous events: show low takes priority over frame_tick.
- Box test is half-open: X_POS <= xg < X_POS + WIDTH and top <= yg < top + HEIGHT.
  - All sums are computed in 11 bits, so no wrap occurs.
  - Rows beyond 1023 are simply never matched.
- ROM addressing: rom_x = (xg - X_POS) >> SCALE_SHIFT and rom_y = (yg - top) >> SCALE_SHIFT, truncated to the port widths. Values are don't-care outside the box.
- Pipeline, one cycle total:
  - Cycle t: register in_box_q <= in_box & visible & (state != HIDDEN).
  - Cycle t+1: rgb = rom_rgb and on = in_box_q & (rom_rgb != TRANSPARENT).
  - Downstream must delay its sync and blanking signals by one cycle to match.
- `top` is also sampled only at frame_tick, never in the middle of a line.

Decomposition:
- Shared package (display_pkg): COLOR_W = 12, COORD_W = 10, the TRANSPARENT default and screen dimensions 640x480. These are reused by every overlay block.
- Sub-module: banner_anim_fsm, covering the state, top, blink_cnt, visible and settled logic driven by show and frame_tick.
- The parent keeps the box compare, address generation and pipeline register.

Test Plan:
- Reset mid-slide: assert rst asynchronously between clock edges -> on = 0 and settled = 0 immediately. After release, state is HIDDEN and top = 0.
- Slide (defaults): with show = 1, top goes 0 -> 4 -> ... -> 80 over 20 frame_ticks. settled rises on the 20th tick. top never exceeds 80, including with SLIDE_STEP = 7, where the last step saturates from 77 to 80.
- Edge pixels in HOLD, rom_rgb = 12'h0f0:
  - (84, 80) -> on = 1 one cycle later, rom_x = 0, rom_y = 0.
  - (555, 399) -> on = 1, rom_x = 235, rom_y = 159.
  - (556, 80) and (84, 400) -> on = 0.
- Transparency: pixel inside the box with rom_rgb = 12'h3b9 -> on = 0. With rom_rgb = 12'h3b8 -> on = 1 and rgb = 12'h3b8.
- Blink: BLINK_FRAMES = 3 -> in HOLD, visible toggles on ticks 3, 6 and 9. With BLINK_FRAMES = 0, visible stays 1 for 100 ticks.
- Abort:
  - show falls in the same cycle as frame_tick during SLIDE -> next cycle is HIDDEN, on = 0 and top = Y_START.
  - show rises again -> the slide restarts from Y_START.

Source files
------------

// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
//   Definitions shared by every overlay block that sits between the VGA
//   pixel-coordinate generator and the top-level colour priority mux.
//   - COLOR_W / COORD_W : widths of a 4:4:4 RGB pixel and of a screen coordinate
//   - SCREEN_W/SCREEN_H : visible raster size (640x480)
//   - TRANSPARENT_KEY   : default colour key that overlays treat as see-through
//   - banner_state_e    : animation states of the banner overlay
// -----------------------------------------------------------------------------
package display_pkg;

   localparam int COLOR_W  = 12;
   localparam int COORD_W  = 10;
   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   localparam logic [COLOR_W-1:0] TRANSPARENT_KEY = 12'h3b9;

   typedef logic [COLOR_W-1:0] color_t;
   typedef logic [COORD_W-1:0] coord_t;

   typedef enum logic [1:0] {
      ST_HIDDEN = 2'd0,
      ST_SLIDE  = 2'd1,
      ST_HOLD   = 2'd2
   } banner_state_e;

endpackage : display_pkg

// File: rtl/banner_anim_fsm.sv
// -----------------------------------------------------------------------------
// banner_anim_fsm
//   Animation controller of the banner overlay. While show_i is high the
//   banner slides from Y_START down to Y_FINAL by SLIDE_STEP rows per frame,
//   then holds, optionally blinking every BLINK_FRAMES frames. Dropping
//   show_i hides the banner at once and rewinds the animation.
//
//   Ports
//     clk          in   pixel clock
//     rst          in   asynchronous, active-high reset
//     show_i       in   level request to display the banner
//     frame_tick_i in   one-cycle pulse at the start of vertical blank
//     top_o        out  current top row of the banner
//     visible_o    out  banner is currently drawn (blink phase)
//     active_o     out  FSM is out of HIDDEN
//     settled_o    out  slide complete (HOLD)
// -----------------------------------------------------------------------------
module banner_anim_fsm
   import display_pkg::*;
#(
   parameter int Y_START      = 0,
   parameter int Y_FINAL      = 80,
   parameter int SLIDE_STEP   = 4,
   parameter int BLINK_FRAMES = 30
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               show_i,
   input  logic               frame_tick_i,
   output logic [COORD_W-1:0] top_o,
   output logic               visible_o,
   output logic               active_o,
   output logic               settled_o
);

   // One extra bit so top + SLIDE_STEP can never wrap before the clamp.
   localparam int TOP_W   = COORD_W + 1;
   localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [TOP_W-1:0]   Y_FINAL_X  = TOP_W'(Y_FINAL);
   localparam logic [TOP_W-1:0]   STEP_X     = TOP_W'(SLIDE_STEP);
   localparam logic [COORD_W-1:0] Y_START_C  = COORD_W'(Y_START);
   localparam logic [COORD_W-1:0] Y_FINAL_C  = COORD_W'(Y_FINAL);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

   banner_state_e      state_q, state_d;
   logic [COORD_W-1:0] top_q, top_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               visible_q, visible_d;
   logic [TOP_W-1:0]   top_sum;

   assign top_sum = {1'b0, top_q} + STEP_X;

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      state_d     = state_q;
      top_d       = top_q;
      blink_cnt_d = blink_cnt_q;
      visible_d   = visible_q;

      if (!show_i) begin
         // Dropping the request beats any simultaneous frame tick.
         state_d     = ST_HIDDEN;
         top_d       = Y_START_C;
         blink_cnt_d = '0;
         visible_d   = 1'b0;
      end else begin
         unique case (state_q)
            ST_HIDDEN: begin
               state_d     = ST_SLIDE;
               top_d       = Y_START_C;
               blink_cnt_d = '0;
               visible_d   = 1'b1;
            end
            ST_SLIDE: begin
               // Position changes only at vertical blank, never mid-frame.
               if (frame_tick_i) begin
                  if (top_sum >= Y_FINAL_X) begin
                     top_d   = Y_FINAL_C;
                     state_d = ST_HOLD;
                  end else begin
                     top_d = top_sum[COORD_W-1:0];
                  end
               end
            end
            ST_HOLD: begin
               if (frame_tick_i && (BLINK_FRAMES != 0)) begin
                  if (blink_cnt_q == BLINK_LAST) begin
                     blink_cnt_d = '0;
                     visible_d   = ~visible_q;
                  end else begin
                     blink_cnt_d = blink_cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d = ST_HIDDEN;
            end
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before the edge, independent of block evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_HIDDEN;
         top_q       <= Y_START_C;
         blink_cnt_q <= '0;
         visible_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         top_q       <= top_d;
         blink_cnt_q <= blink_cnt_d;
         visible_q   <= visible_d;
      end
   end

   assign top_o     = top_q;
   assign visible_o = visible_q;
   assign active_o  = (state_q != ST_HIDDEN);
   assign settled_o = (state_q == ST_HOLD);

endmodule : banner_anim_fsm

// File: rtl/banner_overlay_display.sv
// -----------------------------------------------------------------------------
// banner_overlay_display
//   Full-screen banner sprite (GAME OVER, STAGE CLEAR, PAUSE, ...). Tests the
//   current pixel against the animated banner box, addresses an external
//   synchronous ROM with integer upscaling and flags opaque banner pixels.
//   Output is one cycle behind xg/yg; downstream delays sync/blank to match.
//
//   Ports
//     clk        in   pixel clock
//     rst        in   asynchronous, active-high reset
//     show       in   level request to display the banner
//     frame_tick in   one-cycle pulse at the start of vertical blank
//     xg, yg     in   current pixel column / row
//     rom_x      out  ROM column address (combinational)
//     rom_y      out  ROM row address (combinational)
//     rom_rgb    in   ROM data, one cycle after the address
//     rgb        out  pixel colour, aligned with on
//     on         out  banner pixel is opaque and visible this cycle
//     settled    out  slide animation complete
// -----------------------------------------------------------------------------
module banner_overlay_display
   import display_pkg::*;
#(
   parameter int           WIDTH        = 472,
   parameter int           HEIGHT       = 320,
   parameter int           SCALE_SHIFT  = 1,
   parameter int           X_POS        = 84,
   parameter int           Y_START      = 0,
   parameter int           Y_FINAL      = 80,
   parameter int           SLIDE_STEP   = 4,
   parameter int           BLINK_FRAMES = 30,
   parameter logic [11:0]  TRANSPARENT  = TRANSPARENT_KEY,
   parameter int           ROM_XW       = 8,
   parameter int           ROM_YW       = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               show,
   input  logic               frame_tick,
   input  logic [COORD_W-1:0] xg,
   input  logic [COORD_W-1:0] yg,
   output logic [ROM_XW-1:0]  rom_x,
   output logic [ROM_YW-1:0]  rom_y,
   input  logic [COLOR_W-1:0] rom_rgb,
   output logic [COLOR_W-1:0] rgb,
   output logic               on,
   output logic               settled
);

   // Box bounds are formed one bit wider than a coordinate so that
   // X_POS + WIDTH and top + HEIGHT never wrap; rows past 1023 never match.
   localparam int EXT_W = COORD_W + 1;

   localparam logic [EXT_W-1:0] X_LO = EXT_W'(X_POS);
   localparam logic [EXT_W-1:0] X_HI = EXT_W'(X_POS + WIDTH);
   localparam logic [EXT_W-1:0] H_X  = EXT_W'(HEIGHT);

   logic [COORD_W-1:0] anim_top;
   logic               anim_visible;
   logic               anim_active;
   logic [EXT_W-1:0]   x_ext, y_ext;
   logic [EXT_W-1:0]   y_lo, y_hi;
   logic [EXT_W-1:0]   x_off, y_off;
   logic               in_box;
   logic               in_box_d, in_box_q;

   banner_anim_fsm #(
      .Y_START      (Y_START),
      .Y_FINAL      (Y_FINAL),
      .SLIDE_STEP   (SLIDE_STEP),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_fsm (
      .clk          (clk),
      .rst          (rst),
      .show_i       (show),
      .frame_tick_i (frame_tick),
      .top_o        (anim_top),
      .visible_o    (anim_visible),
      .active_o     (anim_active),
      .settled_o    (settled)
   );

   assign x_ext = {1'b0, xg};
   assign y_ext = {1'b0, yg};
   assign y_lo  = {1'b0, anim_top};
   assign y_hi  = {1'b0, anim_top} + H_X;

   // Half-open box: left/top edges are inside, right/bottom edges outside.
   assign in_box = (x_ext >= X_LO) && (x_ext < X_HI) &&
                   (y_ext >= y_lo) && (y_ext < y_hi);

   // Offsets are meaningless outside the box; the ROM output is then masked
   // by in_box_q anyway.
   assign x_off = x_ext - X_LO;
   assign y_off = y_ext - y_lo;
   assign rom_x = ROM_XW'(x_off >> SCALE_SHIFT);
   assign rom_y = ROM_YW'(y_off >> SCALE_SHIFT);

   assign in_box_d = in_box & anim_visible & anim_active;

   // Matches the one-cycle read latency of the synchronous ROM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_box_q <= 1'b0;
      end else begin
         in_box_q <= in_box_d;
      end
   end

   assign rgb = rom_rgb;
   assign on  = in_box_q & (rom_rgb != TRANSPARENT);

endmodule : banner_overlay_display

// File: tb/tb_banner_overlay_display.sv
module tb_banner_overlay_display;
   import display_pkg::*;

   // Shared geometry of all three instances; they differ in step and blink.
   localparam int YS = 0;
   localparam int YF = 80;
   localparam int XP = 84;
   localparam int W  = 472;
   localparam int H  = 320;
   localparam int SH = 1;
   localparam logic [11:0] KEY = 12'h3b9;

   int step_m  [3] = '{4, 7, 4};
   int blink_m [3] = '{30, 3, 0};

   logic        clk = 1'b0;
   logic        rst;
   logic        show, frame_tick;
   logic [9:0]  xg, yg;
   logic [11:0] rom_rgb;

   logic [2:0][7:0]  rom_x_v, rom_y_v;
   logic [2:0][11:0] rgb_v;
   logic [2:0]       on_v, settled_v;
   logic [2:0][9:0]  top_obs;
   logic [2:0]       vis_obs;

   always #5 clk = ~clk;

   banner_overlay_display dut_a (
      .clk(clk), .rst(rst), .show(show), .frame_tick(frame_tick),
      .xg(xg), .yg(yg), .rom_x(rom_x_v[0]), .rom_y(rom_y_v[0]),
      .rom_rgb(rom_rgb), .rgb(rgb_v[0]), .on(on_v[0]), .settled(settled_v[0])
   );

   banner_overlay_display #(.SLIDE_STEP(7), .BLINK_FRAMES(3)) dut_b (
      .clk(clk), .rst(rst), .show(show), .frame_tick(frame_tick),
      .xg(xg), .yg(yg), .rom_x(rom_x_v[1]), .rom_y(rom_y_v[1]),
      .rom_rgb(rom_rgb), .rgb(rgb_v[1]), .on(on_v[1]), .settled(settled_v[1])
   );

   banner_overlay_display #(.BLINK_FRAMES(0)) dut_c (
      .clk(clk), .rst(rst), .show(show), .frame_tick(frame_tick),
      .xg(xg), .yg(yg), .rom_x(rom_x_v[2]), .rom_y(rom_y_v[2]),
      .rom_rgb(rom_rgb), .rgb(rgb_v[2]), .on(on_v[2]), .settled(settled_v[2])
   );

   assign top_obs[0] = dut_a.anim_top;
   assign top_obs[1] = dut_b.anim_top;
   assign top_obs[2] = dut_c.anim_top;
   assign vis_obs[0] = dut_a.anim_visible;
   assign vis_obs[1] = dut_b.anim_visible;
   assign vis_obs[2] = dut_c.anim_visible;

   int n_checks = 0;
   int n_fails  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // The banner is described by "is it requested" and "how many frame ticks
   // have been seen since it appeared"; everything else is derived.
   bit m_active = 0;
   int m_n      = 0;
   bit exp_inbox [3]  = '{0, 0, 0};
   bit next_inbox [3] = '{0, 0, 0};
   bit drv_show, drv_tick;

   function automatic int settle_ticks(int i);
      int d = YF - YS;
      if (d == 0) return 1;
      return (d + step_m[i] - 1) / step_m[i];
   endfunction

   function automatic int m_top(int i);
      int t;
      if (!m_active) return YS;
      t = YS + m_n * step_m[i];
      return (t > YF) ? YF : t;
   endfunction

   function automatic bit m_settled(int i);
      return m_active && (m_n >= settle_ticks(i));
   endfunction

   function automatic bit m_visible(int i);
      int h;
      if (!m_active) return 1'b0;
      if (!m_settled(i) || blink_m[i] == 0) return 1'b1;
      h = m_n - settle_ticks(i);
      return ((h / blink_m[i]) % 2) == 0;
   endfunction

   function automatic bit m_in_box(int i, int x, int y);
      return (x >= XP) && (x < XP + W) && (y >= m_top(i)) && (y < m_top(i) + H);
   endfunction

   // Drive one cycle's inputs (just after a rising edge) and check outputs.
   task automatic drive(input bit s, input bit t, input int x, input int y,
                        input logic [11:0] c);
      logic [7:0] ex, ey;
      show = s; frame_tick = t; xg = 10'(x); yg = 10'(y); rom_rgb = c;
      drv_show = s; drv_tick = t;
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("on[%0d]", i), 32'(on_v[i]), 32'(exp_inbox[i] && (c != KEY)));
         check($sformatf("settled[%0d]", i), 32'(settled_v[i]), 32'(m_settled(i)));
         check($sformatf("top[%0d]", i), 32'(top_obs[i]), 32'(m_top(i)));
         check($sformatf("visible[%0d]", i), 32'(vis_obs[i]), 32'(m_visible(i)));
         if (exp_inbox[i] && (c != KEY))
            check($sformatf("rgb[%0d]", i), 32'(rgb_v[i]), 32'(c));
         if (m_in_box(i, x, y)) begin
            ex = 8'((x - XP) >> SH);
            ey = 8'((y - m_top(i)) >> SH);
            check($sformatf("rom_x[%0d]", i), 32'(rom_x_v[i]), 32'(ex));
            check($sformatf("rom_y[%0d]", i), 32'(rom_y_v[i]), 32'(ey));
         end
         next_inbox[i] = m_visible(i) && m_in_box(i, x, y);
      end
   endtask

   task automatic advance();
      @(posedge clk);
      if (rst) begin
         m_active = 0; m_n = 0;
         for (int i = 0; i < 3; i++) exp_inbox[i] = 1'b0;
      end else begin
         if (!drv_show) begin
            m_active = 0; m_n = 0;
         end else if (!m_active) begin
            m_active = 1; m_n = 0;
         end else if (drv_tick) begin
            m_n++;
         end
         for (int i = 0; i < 3; i++) exp_inbox[i] = next_inbox[i];
      end
      #1;
   endtask

   task automatic cycle(input bit s, input bit t, input int x, input int y,
                        input logic [11:0] c);
      drive(s, t, x, y, c);
      advance();
   endtask

   task automatic random_run(input int cycles, input int tick_every);
      logic [11:0] c;
      for (int k = 0; k < cycles; k++) begin
         c = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
         cycle(1'b1, (k % tick_every) == tick_every - 1,
               int'($urandom_range(70, 570)), int'($urandom_range(0, 420)), c);
      end
   endtask

   initial begin
      rst = 1'b1; show = 1'b0; frame_tick = 1'b0;
      xg = '0; yg = '0; rom_rgb = '0;
      drv_show = 0; drv_tick = 0;
      @(posedge clk); @(posedge clk); #1;

      // Reset state.
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_on[%0d]", i), 32'(on_v[i]), 32'd0);
         check($sformatf("rst_settled[%0d]", i), 32'(settled_v[i]), 32'd0);
         check($sformatf("rst_top[%0d]", i), 32'(top_obs[i]), 32'(YS));
         check($sformatf("rst_visible[%0d]", i), 32'(vis_obs[i]), 32'd0);
      end
      rst = 1'b0;
      cycle(1'b0, 1'b0, 100, 100, 12'h0f0);

      // Slide with random pixels: a settles on tick 20, b on tick 12 (77->80).
      random_run(60, 2);
      check("slide_top_a", 32'(top_obs[0]), 32'd80);
      check("slide_top_b", 32'(top_obs[1]), 32'd80);

      // Edge pixels in HOLD.
      drive(1'b1, 1'b0, 84, 80, 12'h0f0);
      check("edge_tl_rom_x", 32'(rom_x_v[0]), 32'd0);
      check("edge_tl_rom_y", 32'(rom_y_v[0]), 32'd0);
      advance();
      drive(1'b1, 1'b0, 555, 399, 12'h0f0);
      check("edge_tl_on", 32'(on_v[0]), 32'd1);
      check("edge_br_rom_x", 32'(rom_x_v[0]), 32'd235);
      check("edge_br_rom_y", 32'(rom_y_v[0]), 32'd159);
      advance();
      drive(1'b1, 1'b0, 556, 80, 12'h0f0);
      check("edge_br_on", 32'(on_v[0]), 32'd1);
      advance();
      drive(1'b1, 1'b0, 84, 400, 12'h0f0);
      check("edge_right_on", 32'(on_v[0]), 32'd0);
      advance();
      drive(1'b1, 1'b0, 200, 200, 12'h0f0);
      check("edge_bottom_on", 32'(on_v[0]), 32'd0);
      advance();

      // Transparency key.
      drive(1'b1, 1'b0, 200, 200, 12'h3b9);
      check("key_on", 32'(on_v[0]), 32'd0);
      advance();
      drive(1'b1, 1'b0, 200, 200, 12'h3b8);
      check("near_key_on", 32'(on_v[0]), 32'd1);
      check("near_key_rgb", 32'(rgb_v[0]), 32'h3b8);
      advance();

      // Abort mid-slide: show falls together with a frame tick.
      cycle(1'b0, 1'b0, 0, 0, 12'h0f0);
      cycle(1'b1, 1'b0, 0, 0, 12'h0f0);
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1, 1'b0, 300, 50, 12'h0f0);
         cycle(1'b1, 1'b1, 300, 50, 12'h0f0);
      end
      check("abort_pre_top", 32'(top_obs[0]), 32'd20);
      cycle(1'b0, 1'b1, 0, 0, 12'h0f0);
      drive(1'b0, 1'b0, 300, 50, 12'h0f0);
      check("abort_top", 32'(top_obs[0]), 32'(YS));
      check("abort_on", 32'(on_v[0]), 32'd0);
      advance();
      drive(1'b1, 1'b0, 300, 50, 12'h0f0);
      check("abort_on_late", 32'(on_v[0]), 32'd0);
      advance();
      cycle(1'b1, 1'b1, 300, 50, 12'h0f0);
      check("restart_top", 32'(top_obs[0]), 32'(YS + 4));

      // Long hold: b blinks every 3 frames, c never blinks.
      random_run(280, 2);
      check("long_vis_c", 32'(vis_obs[2]), 32'd1);

      // Asynchronous reset mid-slide.
      cycle(1'b0, 1'b0, 0, 0, 12'h0f0);
      cycle(1'b1, 1'b0, 0, 0, 12'h0f0);
      for (int k = 0; k < 15; k++) cycle(1'b1, 1'b1, 0, 0, 12'h0f0);
      cycle(1'b1, 1'b0, 200, 100, 12'h0f0);
      drive(1'b1, 1'b0, 200, 100, 12'h0f0);
      check("pre_rst_on_a", 32'(on_v[0]), 32'd1);
      check("pre_rst_settled_b", 32'(settled_v[1]), 32'd1);
      rst = 1'b1;
      #1;
      check("async_rst_on_a", 32'(on_v[0]), 32'd0);
      check("async_rst_settled_b", 32'(settled_v[1]), 32'd0);
      check("async_rst_top_a", 32'(top_obs[0]), 32'(YS));
      advance();
      rst = 1'b0;
      cycle(1'b0, 1'b0, 200, 100, 12'h0f0);
      random_run(20, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule : tb_banner_overlay_display
